// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4-column x 5-row matrix keypad one column at a time.
//   Row inputs are synchronised and debounced. Each accepted press
//   produces a one-cycle newkey pulse with a 5-bit keycode. Ghost
//   presses (two or more rows low in the driven column) are rejected.
//   Auto-repeat is not supported.
//
// Ports
//   clock    : system clock
//   reset    : asynchronous, active-low reset
//   row_n    : keypad rows, active-low, asynchronous to clock
//   col_n    : one-hot active-low column strobes (registered)
//   newkey   : one-clock pulse per accepted press
//   keycode  : {row_idx[2:0], col_idx[1:0]}; updated only with newkey
//   key_held : high from the newkey cycle until the release is accepted
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] row_n,
  output logic [3:0] col_n,
  output logic       newkey,
  output logic [4:0] keycode,
  output logic       key_held
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_N    = 4'(DEBOUNCE);

  typedef enum logic [1:0] {SCAN, DEB, HELD} state_t;

  state_t        state;
  logic [4:0]    r1;
  logic [4:0]    rs;
  logic [CW-1:0] cnt;
  logic [1:0]    col_idx;
  logic [4:0]    cand;
  logic [3:0]    match;
  logic [3:0]    rel;

  logic [2:0] nlow;
  logic [2:0] row_idx;
  logic       hit;
  logic       none;
  logic       sample;
  logic [1:0] next_col;
  logic [4:0] code;

  // Two-flop synchroniser; reset value is "all rows released".
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r1 <= '1;
      rs <= '1;
    end else begin
      r1 <= row_n;
      rs <= r1;
    end
  end

  always_comb begin
    nlow    = '0;
    row_idx = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (!rs[i]) begin
        nlow    = nlow + 3'd1;
        row_idx = 3'(i);
      end
    end
    hit      = (nlow == 3'd1);
    none     = (nlow == 3'd0);
    sample   = (cnt == CNT_LAST);
    next_col = col_idx + 2'd1;
    code     = {row_idx, col_idx};
  end

  // col_idx only ever changes at a sample point, where the dwell counter
  // wraps to 0 anyway, so the restart-on-column-change rule needs no
  // separate term.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (sample) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= SCAN;
      col_idx  <= '0;
      col_n    <= 4'b1110;
      cand     <= '0;
      match    <= '0;
      rel      <= '0;
      newkey   <= 1'b0;
      keycode  <= '0;
      key_held <= 1'b0;
    end else begin
      newkey <= 1'b0;
      if (sample) begin
        case (state)
          SCAN: begin
            if (hit) begin
              cand  <= code;
              match <= 4'd1;
              if (DEB_N == 4'd1) begin
                newkey   <= 1'b1;
                keycode  <= code;
                key_held <= 1'b1;
                rel      <= '0;
                state    <= HELD;
              end else begin
                state <= DEB;
              end
            end else begin
              col_idx <= next_col;
              col_n   <= ~(4'b0001 << next_col);
            end
          end
          DEB: begin
            if (hit && (code == cand)) begin
              if (match + 4'd1 == DEB_N) begin
                newkey   <= 1'b1;
                keycode  <= cand;
                key_held <= 1'b1;
                rel      <= '0;
                state    <= HELD;
              end else begin
                match <= match + 4'd1;
              end
            end else begin
              col_idx <= next_col;
              col_n   <= ~(4'b0001 << next_col);
              state   <= SCAN;
            end
          end
          HELD: begin
            // Any row activity in the held column restarts the release count;
            // other keys never produce a pulse here.
            if (none) begin
              if (rel + 4'd1 == DEB_N) begin
                rel      <= '0;
                key_held <= 1'b0;
                col_idx  <= next_col;
                col_n    <= ~(4'b0001 << next_col);
                state    <= SCAN;
              end else begin
                rel <= rel + 4'd1;
              end
            end else begin
              rel <= '0;
            end
          end
          default: begin
            state <= SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Drives a 4-column x 5-row matrix keypad and produces the newkey/keycode pair consumed by the calculator's keypad interpreter. It strobes one column at a time, synchronises and debounces the row inputs, and emits a one-cycle newkey pulse with a 5-bit keycode per debounced press. Ghost presses (more than one row low in a column) are rejected. Auto-repeat is not supported.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven per scan step (dwell); legal range is SCAN_DIV >= 4.
DEBOUNCE, 4, consecutive identical samples needed to accept a press or a release; legal range is 1..15.

Ports:
clock  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
row_n  input  5  keypad rows, pulled up externally; low means a key is closed in the driven column; asynchronous.
col_n  output  4  column strobes, one-hot active-low; exactly one bit is low at all times.
newkey  output  1  high for exactly one clock per accepted press.
keycode  output  5  {row_idx[2:0], col_idx[1:0]}, values 0..19; valid while newkey is high and holds its value until the next press.
key_held  output  1  high from the newkey cycle until the release is accepted.

Behaviour:
- Reset (reset=0, asynchronous): state=SCAN, col_idx=0, col_n=4'b1110, newkey=0, keycode=0, key_held=0, all counters and the synchroniser cleared to "all rows high". Asserting reset mid-debounce or mid-hold discards the key. No newkey pulse is generated on reset exit.
- Synchroniser: row_n passes through a 2-flop synchroniser. All decisions use the synchronised value (rs).
- Dwell counter: counts 0..SCAN_DIV-1 and wraps. The "sample point" is the cycle where the count = SCAN_DIV-1. It restarts at 0 whenever col_idx changes.
- Row decode at a sample point:
  - hit = exactly one rs bit low.
  - row_idx = index of that bit.
  - none = all high.
  - multi = two or more low.
- SCAN: drives col_idx. At the sample point:
  - hit: latch cand={row_idx,col_idx}, set match=1. If DEBOUNCE=1, accept immediately; otherwise go to DEB.
  - none or multi: col_idx = col_idx+1 (wraps 3 to 0), stay in SCAN.
- DEB: the column is held. At each sample point:
  - same hit as cand: match+1. When match reaches DEBOUNCE, accept.
  - anything else: col_idx+1, go to SCAN.
- Accept: in the cycle after the accepting sample point, newkey=1, keycode=cand, key_held=1, go to HELD. newkey returns to 0 on the next cycle.
- HELD: the column is held. At each sample point:
  - none: rel+1.
  - anything else: rel=0.
  - When rel reaches DEBOUNCE: key_held=0, col_idx+1, go to SCAN.
  - Other keys pressed during HELD are ignored, with no pulse and no rollover.
- Output register: keycode changes only in the newkey cycle.
- col_n = ~(1<<col_idx) is registered and changes only on col_idx updates.
- Width rules:
  - dwell counter is clog2(SCAN_DIV) bits.
  - match and rel are 4 bits, with saturation not needed given the DEBOUNCE range.
- A press shorter than DEBOUNCE sample periods never produces newkey.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE=3.
1. Reset, no keys → col_n cycles 1110, 1101, 1011, 0111, 1110 every 4 clocks; newkey is never high; key_held=0.
2. Hold row 2 / col 1 from reset → matching samples at clocks 7, 11 and 15 (counted from reset release, with the sync delay absorbed); newkey pulses one cycle at clock 16 with keycode=9 (5'b01001). col_n stays at 1101 while the key is held; key_held=1.
3. Release the key from scenario 2 → key_held falls after 3 all-high samples; scanning resumes at col_n=1011; no second newkey is generated.
4. Bounce: row 4 / col 3 low for 2 sample periods, high for 1, then held → the first attempt aborts; exactly one newkey is generated with keycode=19 (5'b10011).
5. Ghost: rows 0 and 1 both low on col 0 → no newkey; the scan keeps advancing. Releasing row 1 afterwards → newkey with keycode=0.
6. Assert reset during HELD → col_n=1110, key_held=0, newkey=0 immediately. With the key still held after reset release, a fresh debounce runs and exactly one newkey is produced.
